fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Brief    : Requester streams plus FIFO write port seen by fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          wr_full;
  logic [IDW-1:0]                grant_id;
  logic                          grant_active;

  // slave = arbiter side, master = requesters + FIFO side
  modport slave (
    input  req_valid, req_last, req_data, wr_full,
    output req_ready, wr_en, wr_data, grant_id, grant_active
  );

  modport master (
    output req_valid, req_last, req_data, wr_full,
    input  req_ready, wr_en, wr_data, grant_id, grant_active
  );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ valid/ready/last requesters. Optional per-requester beat
//            statistics when FIFO_WR_ARBITER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fifo_wr_arbiter_if.slave           bus
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [15:0]                stat_beats
`endif
);

  localparam int             IDW         = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX    = IDW'(NUM_REQ - 1);
  localparam logic [8:0]     BURST_LIMIT = 9'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic               bursting;
  logic               grantee_valid;
  logic               grantee_last;
  logic               accept;
  logic               end_burst;
  logic [8:0]         next_cnt;
  logic [NUM_REQ-1:0] ready_w;

  // First valid requester at or after rr_ptr; wrap is explicit so
  // non-power-of-two NUM_REQ never lands on an unused index.
  always_comb begin
    logic [IDW-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  assign bursting      = (state_q == ST_BURST) && !rst;
  assign grantee_valid = bus.req_valid[grant_id_q];
  assign grantee_last  = bus.req_last[grant_id_q];
  assign accept        = bursting && !bus.wr_full && grantee_valid;
  assign next_cnt      = {1'b0, beat_cnt_q} + 9'd1;

  always_comb begin
    ready_w = '0;
    if (bursting && !bus.wr_full) begin
      ready_w[grant_id_q] = 1'b1;
    end
  end

  assign bus.req_ready    = ready_w;
  assign bus.wr_en        = accept;
  assign bus.wr_data      = accept ? bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = (state_q == ST_BURST);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    end_burst  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_BURST;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        // A full FIFO freezes everything, including a pending yield.
        if (!bus.wr_full) begin
          if (!grantee_valid) begin
            end_burst = 1'b1;
          end else begin
            beat_cnt_d = next_cnt[7:0];
            if (grantee_last || (next_cnt == BURST_LIMIT)) begin
              end_burst = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_burst) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
      rr_ptr_d   = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  // Slots beyond NUM_REQ exist only so stat_sel never indexes out of range.
  localparam int NSLOT = 1 << IDW;

  logic [15:0] stat_cnt_q [NSLOT];
  logic [15:0] stat_cnt_d [NSLOT];
  logic [15:0] stat_beats_q, stat_beats_d;

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (accept && (grant_id_q == IDW'(i)) && (stat_cnt_q[i] != 16'hFFFF)) begin
        stat_cnt_d[i] = stat_cnt_q[i] + 16'd1;
      end
    end
    stat_beats_d = stat_cnt_q[stat_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        stat_cnt_q[i] <= '0;
      end
      stat_beats_q <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        stat_cnt_q[i] <= stat_cnt_d[i];
      end
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_beats = stat_beats_q;
`endif

endmodule

`default_nettype wire
